// File: rtl/gpu_text_scanout.sv
// Text-mode scanout: sweeps one frame of 64-bit framebuffer words and streams 4 x 16-bit cells per word.
// Optional GPU_SCANOUT_PREFETCH_EN adds a one-word prefetch register so cells stream without fetch bubbles.
module gpu_text_scanout #(
  parameter int          COLUMNS      = 80,
  parameter int          ROWS         = 30,
  parameter logic [63:0] BASE_ADDRESS = 64'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic [63:0] fb_address,
  input  logic [63:0] fb_data,
  output logic [15:0] char_out,
  output logic        char_valid,
  input  logic        char_ready,
  output logic [7:0]  char_column,
  output logic [7:0]  char_row,
  output logic        frame_done
);

  localparam int             WORDS     = COLUMNS * ROWS / 4;
  localparam int             IW        = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0]  LAST_WORD = IW'(WORDS - 1);
  localparam logic [7:0]     LAST_COL  = 8'(COLUMNS - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [63:0]   word_reg;
  logic [1:0]    lane;
  logic [IW-1:0] word_index;
  logic          handshake;
  logic          last_lane;
  logic          last_word;

  assign char_valid = (state == DRAIN);
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);
  assign char_out   = word_reg[{lane, 4'b0000} +: 16];
  assign handshake  = char_valid && char_ready;
  assign last_lane  = (lane == 2'd3);
  assign last_word  = (word_index == LAST_WORD);

`ifdef GPU_SCANOUT_PREFETCH_EN
  logic [63:0] pf_word;
  logic        pf_full;
  logic        pf_pending;
  logic        pf_take;
  logic        more_after_next;

  assign pf_take         = handshake && last_lane && !last_word && pf_full;
  assign more_after_next = ((word_index + IW'(1)) != LAST_WORD);

  // The prefetch address is always one word ahead of word_reg; its data lands one cycle after issue.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pf_word    <= '0;
      pf_full    <= 1'b0;
      pf_pending <= 1'b0;
    end else begin
      pf_pending <= 1'b0;
      if (state == IDLE) begin
        pf_full <= 1'b0;
      end
      if (state == FETCH && !last_word) begin
        pf_pending <= 1'b1;
      end
      if (pf_take) begin
        pf_full    <= 1'b0;
        pf_pending <= more_after_next;
      end
      if (pf_pending) begin
        pf_word <= fb_data;
        pf_full <= 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = FETCH;
        end
      end
      FETCH: state_next = DRAIN;
      DRAIN: begin
        if (handshake && last_lane) begin
          if (last_word) begin
            state_next = DONE;
          end else begin
`ifdef GPU_SCANOUT_PREFETCH_EN
            state_next = pf_full ? DRAIN : FETCH;
`else
            state_next = FETCH;
`endif
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Word/lane/position bookkeeping; column and row track the cell currently on char_out.
  always_ff @(posedge clock) begin
    if (!reset) begin
      word_reg    <= '0;
      lane        <= '0;
      word_index  <= '0;
      fb_address  <= '0;
      char_column <= '0;
      char_row    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            word_index  <= '0;
            fb_address  <= BASE_ADDRESS;
            lane        <= '0;
            char_column <= '0;
            char_row    <= '0;
          end
        end
        FETCH: begin
          word_reg <= fb_data;
          lane     <= '0;
`ifdef GPU_SCANOUT_PREFETCH_EN
          if (!last_word) begin
            fb_address <= fb_address + 64'd1;
          end
`endif
        end
        DRAIN: begin
          if (handshake) begin
            lane <= lane + 2'd1;
            if (char_column == LAST_COL) begin
              char_column <= '0;
              char_row    <= char_row + 8'd1;
            end else begin
              char_column <= char_column + 8'd1;
            end
            if (last_lane && !last_word) begin
              word_index <= word_index + IW'(1);
`ifdef GPU_SCANOUT_PREFETCH_EN
              // fb_address already points at the next word; advance only when loading from prefetch.
              if (pf_full) begin
                word_reg <= pf_word;
                if (more_after_next) begin
                  fb_address <= fb_address + 64'd1;
                end
              end
`else
              fb_address <= fb_address + 64'd1;
`endif
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_text_scanout.sv
// Self-checking bench for gpu_text_scanout: randomized framebuffer contents and backpressure
// compared against a raster-order cell list computed directly from the memory image.
module tb_gpu_text_scanout;

  typedef struct {
    logic [15:0] ch;
    int          col;
    int          row;
  } cell_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic        ready = 1'b0;

  logic        busy0, busy1;
  logic [63:0] fb_address0, fb_address1;
  logic [63:0] fb_data0, fb_data1;
  logic [15:0] char_out0, char_out1;
  logic        char_valid0, char_valid1;
  logic [7:0]  char_column0, char_column1;
  logic [7:0]  char_row0, char_row1;
  logic        frame_done0, frame_done1;

  logic        busy_s, char_valid_s, frame_done_s;
  logic [63:0] fb_address_s;
  logic [15:0] char_out_s;
  logic [7:0]  char_column_s, char_row_s;

  logic [63:0] mem [0:1023];
  int          checks = 0;
  int          errors = 0;
  int          active = 0;
  int          cols, rows, words;
  longint      base;
  longint      addr_min, addr_max;
  cell_t       got_q[$];

  gpu_text_scanout dut0 (
    .clock(clock), .reset(reset), .start(start0), .busy(busy0),
    .fb_address(fb_address0), .fb_data(fb_data0), .char_out(char_out0),
    .char_valid(char_valid0), .char_ready(ready), .char_column(char_column0),
    .char_row(char_row0), .frame_done(frame_done0)
  );

  gpu_text_scanout #(.COLUMNS(40), .ROWS(10), .BASE_ADDRESS(64'd600)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .busy(busy1),
    .fb_address(fb_address1), .fb_data(fb_data1), .char_out(char_out1),
    .char_valid(char_valid1), .char_ready(ready), .char_column(char_column1),
    .char_row(char_row1), .frame_done(frame_done1)
  );

  always #5 clock = ~clock;

  // Framebuffer read port: address registered at posedge, data presented on the following negedge.
  always @(negedge clock) begin
    fb_data0 <= mem[fb_address0[9:0]];
    fb_data1 <= mem[fb_address1[9:0]];
  end

  always_comb begin
    busy_s        = (active != 0) ? busy1 : busy0;
    char_valid_s  = (active != 0) ? char_valid1 : char_valid0;
    frame_done_s  = (active != 0) ? frame_done1 : frame_done0;
    fb_address_s  = (active != 0) ? fb_address1 : fb_address0;
    char_out_s    = (active != 0) ? char_out1 : char_out0;
    char_column_s = (active != 0) ? char_column1 : char_column0;
    char_row_s    = (active != 0) ? char_row1 : char_row0;
  end

  task automatic set_start(input logic v);
    if (active != 0) start1 = v;
    else start0 = v;
  endtask

  task automatic select_dut(input int which);
    active = which;
    if (which != 0) begin
      cols = 40; rows = 10; base = 600;
    end else begin
      cols = 80; rows = 30; base = 0;
    end
    words = cols * rows / 4;
  endtask

  task automatic fill_random();
    for (int i = 0; i < words; i++) mem[base + i] = {$urandom, $urandom};
  endtask

  // One full frame: expected cells come straight from the memory image in raster order.
  task automatic sweep(input int ready_pct, input int pulse_cycle, input int budget, output int cycles);
    cell_t       exp_q[$];
    cell_t       c;
    logic [63:0] d;
    logic        prev_stall, r;
    logic [15:0] p_ch;
    logic [7:0]  p_col, p_row;
    bit          done;
    got_q.delete();
    for (int w = 0; w < words; w++) begin
      d = mem[base + w];
      for (int l = 0; l < 4; l++) begin
        c.ch  = d[16*l +: 16];
        c.col = (4 * w + l) % cols;
        c.row = (4 * w + l) / cols;
        exp_q.push_back(c);
      end
    end
    cycles = -1;
    done = 0;
    prev_stall = 0;
    p_ch = '0; p_col = '0; p_row = '0;
    addr_min = 64'h7fff_ffff;
    addr_max = -1;
    @(negedge clock);
    set_start(1'b1);
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge clock);
      if (k == 0) begin
        set_start(1'b0);
        checks++;
        if (busy_s !== 1'b1) begin
          errors++;
          $display("[TB] FAIL busy_after_start got %b want 1", busy_s);
        end
      end
      if (k == pulse_cycle) set_start(1'b1);
      else if (k == pulse_cycle + 1) set_start(1'b0);
      if (prev_stall) begin
        checks++;
        if (char_valid_s !== 1'b1 || char_out_s !== p_ch || char_column_s !== p_col || char_row_s !== p_row) begin
          errors++;
          $display("[TB] FAIL stall_hold got v=%b %h (%0d,%0d) want v=1 %h (%0d,%0d)",
                   char_valid_s, char_out_s, char_column_s, char_row_s, p_ch, p_col, p_row);
        end
      end
      if (busy_s === 1'b1) begin
        if (longint'(fb_address_s) > addr_max) addr_max = longint'(fb_address_s);
        if (longint'(fb_address_s) < addr_min) addr_min = longint'(fb_address_s);
      end
      if (frame_done_s === 1'b1) begin
        done = 1;
        cycles = k;
        checks++;
        if (exp_q.size() != 0) begin
          errors++;
          $display("[TB] FAIL cells_missing got %0d left want 0", exp_q.size());
        end
        set_start(1'b1);
      end else begin
        r = ($urandom_range(99) < ready_pct);
        ready = r;
        if (char_valid_s === 1'b1 && r) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL extra_cell got %h (%0d,%0d) want none", char_out_s, char_column_s, char_row_s);
          end else begin
            c = exp_q.pop_front();
            if (char_out_s !== c.ch || char_column_s !== 8'(c.col) || char_row_s !== 8'(c.row)) begin
              errors++;
              $display("[TB] FAIL cell got %h (%0d,%0d) want %h (%0d,%0d)",
                       char_out_s, char_column_s, char_row_s, c.ch, c.col, c.row);
            end
          end
          c.ch = char_out_s; c.col = int'(char_column_s); c.row = int'(char_row_s);
          got_q.push_back(c);
        end
        prev_stall = (char_valid_s === 1'b1) && !r;
        p_ch = char_out_s; p_col = char_column_s; p_row = char_row_s;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL frame_timeout got no frame_done want within %0d cycles", budget);
    end
    @(negedge clock);
    set_start(1'b0);
    ready = 1'b0;
    checks++;
    if ({frame_done_s, busy_s} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL done_pulse got done=%b busy=%b want 0 0", frame_done_s, busy_s);
    end
    @(negedge clock);
    checks++;
    if (busy_s !== 1'b0) begin
      errors++;
      $display("[TB] FAIL start_in_done got busy=%b want 0", busy_s);
    end
    checks++;
    if (addr_min < base || addr_max > base + words - 1) begin
      errors++;
      $display("[TB] FAIL addr_range got %0d..%0d want %0d..%0d", addr_min, addr_max, base, base + words - 1);
    end
  endtask

  task automatic test_reset();
    bit seen;
    select_dut(0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({busy0, char_valid0, frame_done0, fb_address0, char_out0, char_column0, char_row0} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_dut0 got busy=%b v=%b done=%b addr=%h",
               busy0, char_valid0, frame_done0, fb_address0);
    end
    checks++;
    if ({busy1, char_valid1, frame_done1, fb_address1, char_out1, char_column1, char_row1} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_dut1 got busy=%b v=%b done=%b addr=%h",
               busy1, char_valid1, frame_done1, fb_address1);
    end
    reset = 1'b1;
    fill_random();
    ready = 1'b1;
    @(negedge clock);
    start0 = 1'b1;
    @(negedge clock);
    start0 = 1'b0;
    repeat (11) @(negedge clock);
    checks++;
    if (char_valid0 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_drain got v=%b want 1", char_valid0);
    end
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({busy0, char_valid0, frame_done0, fb_address0, char_out0, char_column0, char_row0} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_abort got busy=%b v=%b done=%b addr=%h col=%0d row=%0d",
               busy0, char_valid0, frame_done0, fb_address0, char_column0, char_row0);
    end
    reset = 1'b1;
    ready = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clock);
      if (frame_done0 !== 1'b0 || busy0 !== 1'b0) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("[TB] FAIL after_abort got activity want idle");
    end
  endtask

  task automatic test_word_unpack();
    int cyc;
    select_dut(0);
    fill_random();
    mem[0] = 64'h0004_0003_0002_0001;
    sweep(100, -1, 4000, cyc);
    checks++;
    if (got_q.size() < 4) begin
      errors++;
      $display("[TB] FAIL unpack_count got %0d want >=4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (got_q[i].ch !== 16'(i + 1) || got_q[i].col != i || got_q[i].row != 0) begin
          errors++;
          $display("[TB] FAIL unpack_lane%0d got %h (%0d,%0d) want %h (%0d,0)",
                   i, got_q[i].ch, got_q[i].col, got_q[i].row, 16'(i + 1), i);
        end
      end
    end
  endtask

  task automatic test_full_frame();
    int cyc;
    logic [15:0] v;
    select_dut(0);
    for (int i = 0; i < words; i++) begin
      v = 16'(i);
      mem[i] = {v, v, v, v};
    end
    sweep(100, -1, 4000, cyc);
    checks++;
    if (got_q.size() != 2400) begin
      errors++;
      $display("[TB] FAIL full_count got %0d want 2400", got_q.size());
    end
    checks++;
    if (got_q.size() == 0 || got_q[$].col != 79 || got_q[$].row != 29 || got_q[$].ch !== 16'd599) begin
      errors++;
      $display("[TB] FAIL full_last got wrong final cell want %h (79,29)", 16'd599);
    end
    checks++;
`ifdef GPU_SCANOUT_PREFETCH_EN
    if (cyc < 2400 || cyc > 2403) begin
      errors++;
      $display("[TB] FAIL full_cycles got %0d want 2400..2403", cyc);
    end
`else
    if (cyc != 3000) begin
      errors++;
      $display("[TB] FAIL full_cycles got %0d want 3000", cyc);
    end
`endif
  endtask

  task automatic test_backpressure();
    int cyc;
    select_dut(0);
    fill_random();
    sweep(50, -1, 20000, cyc);
    checks++;
    if (got_q.size() != 2400) begin
      errors++;
      $display("[TB] FAIL bp_count got %0d want 2400", got_q.size());
    end
  endtask

  task automatic test_start_while_busy();
    int cyc;
    bit extra;
    select_dut(0);
    fill_random();
    sweep(100, 10, 4000, cyc);
    extra = 0;
    repeat (50) begin
      @(negedge clock);
      if (frame_done0 !== 1'b0 || busy0 !== 1'b0) extra = 1;
    end
    checks++;
    if (extra) begin
      errors++;
      $display("[TB] FAIL start_busy got second frame activity want none");
    end
  endtask

  task automatic test_param_variant();
    int cyc;
    select_dut(1);
    fill_random();
    sweep(50, -1, 5000, cyc);
    checks++;
    if (got_q.size() != 400) begin
      errors++;
      $display("[TB] FAIL var_count got %0d want 400", got_q.size());
    end
    checks++;
    if (got_q.size() == 0 || got_q[$].col != 39 || got_q[$].row != 9) begin
      errors++;
      $display("[TB] FAIL var_last got wrong final cell want (39,9)");
    end
    checks++;
    if (addr_min != 600 || addr_max != 699) begin
      errors++;
      $display("[TB] FAIL var_words got %0d..%0d want 600..699", addr_min, addr_max);
    end
    select_dut(0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    test_reset();
    test_word_unpack();
    test_full_frame();
    test_backpressure();
    test_start_while_busy();
    test_param_variant();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
